prio_queue_custom: RTL

- Parametrised successor to the single-mode heap custom instruction on the C3 custom-instruction port.
- Hardware binary heap with explicit opcodes: push, pop, peek, size, clear.
- Configurable data width, depth, max/min ordering and signed/unsigned compare.
- Every accepted instruction returns exactly one response pulse, with error signalling for full, empty and illegal cases.

---
 rtl/prio_queue_custom.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/prio_queue_custom.sv
// prio_queue_custom: binary-heap priority queue custom instruction with push/pop/peek/size/clear
module prio_queue_custom #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int MAX_HEAP   = 1,
    parameter int SIGNED_CMP = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_v,
    input  logic [4:0]                     rd,
    input  logic [2:0]                     in_op,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           out_v,
    output logic [4:0]                     out_rd,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_err,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic [4:0]        rd_q, rd_d, out_rd_q, out_rd_d;
    logic [DATA_W-1:0] res_q, res_d, out_data_q, out_data_d;
    logic              out_v_q, out_v_d, out_err_q, out_err_d, busy_q, busy_d;
    logic [DATA_W-1:0] heap_q [DEPTH];
    logic              we0, we1;
    logic [IW-1:0]     wa0, wa1, parent, best;
    logic [DATA_W-1:0] wd0, wd1, rsp_data;
    logic              rsp, rsp_err;
    logic [4:0]        rsp_rd;
    logic [CW:0]       lc, rc;

    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic gt, lt;
        gt = (SIGNED_CMP != 0) ? ($signed(a) > $signed(b)) : (a > b);
        lt = (SIGNED_CMP != 0) ? ($signed(a) < $signed(b)) : (a < b);
        return (MAX_HEAP != 0) ? gt : lt;
    endfunction

    // Parent/child indices; children are one bit wider than count so overflow compares as out of range
    always_comb begin
        parent = (idx_q - IW'(1)) >> 1;
        lc     = {CW'(idx_q), 1'b1};
        rc     = lc + (CW+1)'(1);
        best   = idx_q;
        if (lc < {1'b0, count_q} && better(heap_q[IW'(lc)], heap_q[idx_q]))
            best = IW'(lc);
        if (rc < {1'b0, count_q} && better(heap_q[IW'(rc)], heap_q[best]))
            best = IW'(rc);
    end

    // Instruction decode, sift FSM next state, heap write ports and response generation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        rd_d       = rd_q;
        res_d      = res_q;
        out_v_d    = 1'b0;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        we0        = 1'b0;
        we1        = 1'b0;
        wa0        = idx_q;
        wa1        = parent;
        wd0        = heap_q[parent];
        wd1        = heap_q[idx_q];
        rsp        = 1'b0;
        rsp_err    = 1'b0;
        rsp_data   = '0;
        rsp_rd     = rd_q;
        case (state_q)
            IDLE: if (in_v) begin
                rd_d   = rd;
                rsp_rd = rd;
                case (in_op)
                    3'd0: if (count_q == CW'(DEPTH)) begin
                        rsp      = 1'b1;
                        rsp_err  = 1'b1;
                        rsp_data = DATA_W'(count_q);
                    end else begin
                        we0     = 1'b1;
                        wa0     = IW'(count_q);
                        wd0     = in_data;
                        count_d = count_q + CW'(1);
                        idx_d   = IW'(count_q);
                        state_d = SIFT_UP;
                    end
                    3'd1: if (count_q == '0) begin
                        rsp     = 1'b1;
                        rsp_err = 1'b1;
                    end else begin
                        res_d   = heap_q[0];
                        we0     = 1'b1;
                        wa0     = '0;
                        wd0     = heap_q[IW'(count_q - CW'(1))];
                        count_d = count_q - CW'(1);
                        idx_d   = '0;
                        state_d = SIFT_DOWN;
                    end
                    3'd2: begin
                        rsp      = 1'b1;
                        rsp_err  = count_q == '0;
                        rsp_data = (count_q == '0) ? '0 : heap_q[0];
                    end
                    3'd3: begin
                        rsp      = 1'b1;
                        rsp_data = DATA_W'(count_q);
                    end
                    3'd4: begin
                        rsp      = 1'b1;
                        rsp_data = DATA_W'(count_q);
                        count_d  = '0;
                    end
                    default: begin
                        rsp     = 1'b1;
                        rsp_err = 1'b1;
                    end
                endcase
            end
            SIFT_UP: if (idx_q != '0 && better(heap_q[idx_q], heap_q[parent])) begin
                we0   = 1'b1;
                we1   = 1'b1;
                idx_d = parent;
            end else begin
                state_d  = IDLE;
                rsp      = 1'b1;
                rsp_data = DATA_W'(count_q);
            end
            SIFT_DOWN: if (best != idx_q) begin
                we0   = 1'b1;
                wd0   = heap_q[best];
                we1   = 1'b1;
                wa1   = best;
                idx_d = best;
            end else begin
                state_d  = IDLE;
                rsp      = 1'b1;
                rsp_data = res_q;
            end
            default: state_d = IDLE;
        endcase
        if (rsp) begin
            out_v_d    = 1'b1;
            out_rd_d   = rsp_rd;
            out_data_d = rsp_data;
            out_err_d  = rsp_err;
        end
        busy_d = state_d != IDLE;
    end

    // Heap storage: two write ports so a swap completes in one cycle; contents need no reset
    always_ff @(posedge clk) begin
        if (we0) heap_q[wa0] <= wd0;
        if (we1) heap_q[wa1] <= wd1;
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            res_q      <= '0;
            out_v_q    <= 1'b0;
            out_rd_q   <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            res_q      <= res_d;
            out_v_q    <= out_v_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            busy_q     <= busy_d;
        end
    end

    assign out_v    = out_v_q;
    assign out_rd   = out_rd_q;
    assign out_data = out_data_q;
    assign out_err  = out_err_q;
    assign busy     = busy_q;
    assign count    = count_q;
endmodule
